// File: rtl/lane_unpacker.sv
// ---------------------------------------------------------------------------
// lane_unpacker
//
// Accepts a packed word of NLANES lanes (LANE_W bits each) and presents the
// lanes one at a time, lane 0 first, over a valid/ready stream. A new word
// can be accepted in the same cycle the last lane is consumed, so
// back-to-back words stream with no idle cycle between them.
//
// Parameters
//   LANE_W   width of one lane in bits
//   NLANES   lanes per packed word (power of 2, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   packed word offered
//   in_ready   packed word accepted when in_valid && in_ready
//   in_data    packed word, lane i at [i*LANE_W +: LANE_W]
//   out_valid  lane presented
//   out_ready  lane consumed when out_valid && out_ready
//   out_lane   current lane value
//   out_idx    index of current lane
//   out_last   high on the final lane of a word
//   err        (only with LANE_UNPACKER_CHECK_EN) sticky flag, set when a
//              consumed lane differs from its own index, cleared by reset
//
// Optional feature macro: LANE_UNPACKER_CHECK_EN
// ---------------------------------------------------------------------------
module lane_unpacker #(
    parameter int LANE_W = 6,
    parameter int NLANES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NLANES*LANE_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_W-1:0]          out_lane,
    output logic [$clog2(NLANES)-1:0]  out_idx,
    output logic                       out_last
`ifdef LANE_UNPACKER_CHECK_EN
    ,
    output logic                       err
`endif
);

    localparam int IDX_W = $clog2(NLANES);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [NLANES*LANE_W-1:0]  data_q;
    logic [IDX_W-1:0]          idx_q;
    logic [LANE_W-1:0]         lanes [NLANES];
    logic                      in_hs;
    logic                      out_hs;

    // View the held word as an array of lanes so the index selects directly.
    for (genvar g = 0; g < NLANES; g++) begin : g_lanes
        assign lanes[g] = data_q[g*LANE_W +: LANE_W];
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a last-lane handshake returns to IDLE unless a new word is
    // taken in the same cycle, in which case EMIT continues uninterrupted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_hs && out_last && !in_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: lane fields are forced to zero outside EMIT so an idle block
    // shows no stale lane. in_ready opens on the last-lane handshake to allow
    // zero-bubble streaming.
    always_comb begin
        out_valid = 1'b0;
        out_lane  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (state == EMIT) begin
            out_valid = 1'b1;
            out_lane  = lanes[idx_q];
            out_idx   = idx_q;
            out_last  = (idx_q == IDX_W'(NLANES - 1));
        end
        in_ready = (state == IDLE) || (out_valid && out_ready && out_last);
    end

    // Word and index registers. A fresh word always restarts at index 0; the
    // increment after the last lane wraps to 0 because NLANES is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (in_hs) begin
            data_q <= in_data;
            idx_q  <= '0;
        end else if (out_hs) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

`ifdef LANE_UNPACKER_CHECK_EN
    // Sticky self-check: every consumed lane is expected to carry its own
    // index (a ramp pattern), anything else latches err until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (out_hs && (out_lane != LANE_W'(out_idx))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lane_unpacker.sv
// ---------------------------------------------------------------------------
// tb_lane_unpacker
//
// Self-checking bench for lane_unpacker. A queue-based model expands every
// accepted word into its lanes and is compared with the DUT on each falling
// edge; directed sequences add literal expectations at key points.
// Optional feature macro: LANE_UNPACKER_CHECK_EN
// ---------------------------------------------------------------------------
module tb_lane_unpacker;

    localparam int LANE_W = 6;
    localparam int NLANES = 8;
    localparam int IDX_W  = $clog2(NLANES);
    localparam int W      = NLANES * LANE_W;

    localparam logic [W-1:0] W1    = 48'h1C61_440C_2040;
    localparam logic [W-1:0] W2    = 48'hABCD_EF01_2345;
    localparam logic [W-1:0] WONES = 48'hFFFF_FFFF_FFFF;
    localparam logic [W-1:0] WJUNK = 48'h5A5A_5A5A_5A5A;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LANE_W-1:0] out_lane;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
`ifdef LANE_UNPACKER_CHECK_EN
    logic              err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lane_unpacker #(.LANE_W(LANE_W), .NLANES(NLANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef LANE_UNPACKER_CHECK_EN
        ,
        .err       (err)
`endif
    );

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [W-1:0] d,
                                  input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Model: every accepted word becomes NLANES pending lanes in order.
    // ------------------------------------------------------------------
    typedef struct {
        logic [LANE_W-1:0] val;
        int                idx;
    } lane_t;

    lane_t expq[$];
    logic  err_m = 1'b0;

    always @(negedge clk) begin
        logic         exp_valid;
        logic         exp_ready;
        lane_t        front;
        lane_t        item;
        logic [W-1:0] tmp;
        if (!rst_n) begin
            expq.delete();
            err_m = 1'b0;
            check_output("rst_out_valid", 64'(out_valid), 64'd0);
            check_output("rst_in_ready", 64'(in_ready), 64'd1);
            check_output("rst_out_lane", 64'(out_lane), 64'd0);
            check_output("rst_out_idx", 64'(out_idx), 64'd0);
            check_output("rst_out_last", 64'(out_last), 64'd0);
`ifdef LANE_UNPACKER_CHECK_EN
            check_output("rst_err", 64'(err), 64'd0);
`endif
        end else begin
            exp_valid = (expq.size() != 0);
            exp_ready = (expq.size() == 0) || (out_ready && expq.size() == 1);
            check_output("mdl_out_valid", 64'(out_valid), 64'(exp_valid));
            check_output("mdl_in_ready", 64'(in_ready), 64'(exp_ready));
            if (exp_valid) begin
                front = expq[0];
                check_output("mdl_out_lane", 64'(out_lane), 64'(front.val));
                check_output("mdl_out_idx", 64'(out_idx), 64'(front.idx));
                check_output("mdl_out_last", 64'(out_last),
                             64'(front.idx == NLANES - 1));
            end
`ifdef LANE_UNPACKER_CHECK_EN
            check_output("mdl_err", 64'(err), 64'(err_m));
`endif
            if (exp_valid && out_ready) begin
                front = expq.pop_front();
                if (front.val != LANE_W'(front.idx)) err_m = 1'b1;
            end
            if (in_valid && exp_ready) begin
                for (int i = 0; i < NLANES; i++) begin
                    tmp      = in_data >> (i * LANE_W);
                    item.val = tmp[LANE_W-1:0];
                    item.idx = i;
                    expq.push_back(item);
                end
            end
        end
    end

    // Assert reset away from the clock, check at once, release after 2 edges.
    task automatic pulse_reset();
        apply_stimulus(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("rst_now_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_now_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_now_out_idx", 64'(out_idx), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        $display("[TB] lane_unpacker bench start");
        step(3);
        rst_n = 1'b1;
        step(1);

        // Single word, sink always ready: lanes 0..7 on consecutive cycles.
        apply_stimulus(1'b1, W1, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < NLANES; k++) begin
            check_output("t1_out_valid", 64'(out_valid), 64'd1);
            check_output("t1_out_lane", 64'(out_lane), 64'(k));
            check_output("t1_out_idx", 64'(out_idx), 64'(k));
            check_output("t1_out_last", 64'(out_last), 64'(k == NLANES - 1));
            check_output("t1_in_ready", 64'(in_ready), 64'(k == NLANES - 1));
            step(1);
        end
        check_output("t1_idle_valid", 64'(out_valid), 64'd0);
        check_output("t1_idle_ready", 64'(in_ready), 64'd1);

        // Sink stalls for 3 cycles on lane 2; a junk word offered meanwhile
        // must be ignored.
        apply_stimulus(1'b1, W1, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        step(2);
        apply_stimulus(1'b1, WJUNK, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_output("t2_hold_lane", 64'(out_lane), 64'd2);
            check_output("t2_hold_idx", 64'(out_idx), 64'd2);
            check_output("t2_hold_in_ready", 64'(in_ready), 64'd0);
            step(1);
        end
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("t2_resume_idx", 64'(out_idx), 64'd2);
        step(6);
        check_output("t2_idle_valid", 64'(out_valid), 64'd0);

        // Back-to-back words with in_valid held: no bubble between them.
        apply_stimulus(1'b1, W1, 1'b1);
        step(1);
        apply_stimulus(1'b1, W2, 1'b1);
        for (int k = 0; k < NLANES; k++) begin
            check_output("t3_in_ready", 64'(in_ready), 64'(k == NLANES - 1));
            step(1);
        end
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("t3_w2_valid", 64'(out_valid), 64'd1);
        check_output("t3_w2_idx", 64'(out_idx), 64'd0);
        check_output("t3_w2_lane", 64'(out_lane), 64'h05);
        step(NLANES);
        check_output("t3_idle_valid", 64'(out_valid), 64'd0);

        // Reset at index 4 discards the word; next word restarts at 0.
        apply_stimulus(1'b1, W1, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        step(4);
        check_output("t4_at_idx4", 64'(out_idx), 64'd4);
        pulse_reset();
        check_output("t4_after_valid", 64'(out_valid), 64'd0);
        apply_stimulus(1'b1, W2, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("t4_restart_idx", 64'(out_idx), 64'd0);
        check_output("t4_restart_lane", 64'(out_lane), 64'h05);
        step(NLANES);
        check_output("t4_idle_valid", 64'(out_valid), 64'd0);

`ifdef LANE_UNPACKER_CHECK_EN
        // All-ones word trips the sticky error on lane 0; it survives a
        // clean word and is cleared only by reset.
        apply_stimulus(1'b1, WONES, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("t5_err_before", 64'(err), 64'd0);
        check_output("t5_lane0", 64'(out_lane), 64'h3F);
        step(1);
        check_output("t5_err_set", 64'(err), 64'd1);
        step(NLANES - 1);
        apply_stimulus(1'b1, W1, 1'b1);
        step(1);
        apply_stimulus(1'b0, '0, 1'b1);
        step(NLANES);
        check_output("t5_err_sticky", 64'(err), 64'd1);
        pulse_reset();
        check_output("t5_err_cleared", 64'(err), 64'd0);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
